// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider (define SEQ_DIVIDER_UNSIGNED_EN to add the signed_op port)
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs, dvd;
  logic             neg_q, neg_r, zero, sgn, dn, ds;
  logic [WIDTH:0]   shifted, trial;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign sgn = signed_op;
`else
  assign sgn = 1'b1;
`endif
  always_comb begin
    dn      = sgn & dividend[WIDTH-1];
    ds      = sgn & divisor[WIDTH-1];
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      dvd         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rem   <= '0;
          quo   <= dn ? -dividend : dividend;
          dvs   <= ds ? -divisor : divisor;
          dvd   <= dividend;
          neg_q <= dn ^ ds;
          neg_r <= dn;
          zero  <= divisor == '0;
          cnt   <= CW'(WIDTH - 1);
          busy  <= 1'b1;
          state <= (divisor == '0) ? FIX : RUN;
        end
        RUN: begin
          rem   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt - CW'(1);
          state <= (cnt == '0) ? FIX : RUN;
        end
        FIX: begin
          quotient    <= zero ? '1 : (neg_q ? -quo : quo);
          remainder   <= zero ? dvd : (neg_r ? -rem : rem);
          div_by_zero <= zero;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
